tdmrc_byte_tx: RTL and testbench
================================

// Module: tdmrc_byte_tx
// PURPOSE
//  Output-side counterpart of the e_tdmrc byte-serial input path.
//  Accepts a flat NBYTES-byte cipher block, e.g. cipher_flat qualified by done.
//  Streams the block out one byte per transfer on a valid/ready interface, MSB byte first.
//  Double-buffered (shift stage + holding stage) so back-to-back blocks stream with no bubble.
// PARAMETERS
//  NBYTES  5  bytes per block; block width = NBYTES*8
//  WIDTH   8  bits per byte; fixed at 8, other values unsupported
// PORTS
//  clk         in   1         single clock, rising edge
//  rst         in   1         synchronous, active-high reset
//  block_in    in   NBYTES*8  block; byte k = block_in[(NBYTES-k)*8-1 -: 8]
//  block_valid in   1         block_in valid this cycle (one-cycle pulse acceptable)
//  block_ready out  1         = !hold_full; forced 0 while rst=1
//  byte_out    out  8         current output byte
//  byte_valid  out  1         byte_out valid
//  byte_ready  in   1         sink accepts byte_out when byte_valid=1
//  byte_last   out  1         qualifies final byte of a block
//  busy        out  1         shift stage or holding stage occupied
//  overflow    out  1         one-cycle pulse: block_valid while block_ready=0; that block is dropped
// BEHAVIOUR
//  Reset: all state cleared; byte_out=0, byte_valid=0, byte_last=0, busy=0, overflow=0.
//    block_ready=1 on the first cycle after rst deasserts. Mid-stream reset discards both stages.
//  FSM: IDLE -> SEND -> (CSUM, macro only) -> IDLE or SEND.
//    IDLE:
//      - block_valid loads the shift stage directly; byte_idx=0.
//      - Next state SEND; byte_valid=1 the cycle after acceptance (latency 1).
//    SEND:
//      - Transfer = byte_valid & byte_ready; byte_idx increments per transfer.
//      - byte_out/byte_last held stable while byte_valid & !byte_ready.
//      - block_valid with holding stage empty stores the block in holding; ready drops next cycle.
//    Last-byte transfer edge:
//      - Holding full: move holding -> shift, byte_idx=0, stay in SEND. No bubble: next byte 0 the next cycle.
//      - Else block_valid & block_ready: load block_in straight into shift, stay in SEND.
//      - Else go to IDLE; byte_valid=0 the next cycle.
//  byte_out outputs are registered; byte_out = shift[(NBYTES-byte_idx)*8-1 -: 8].
//  byte_idx is ceil(log2(NBYTES+1)) bits and never exceeds NBYTES.
//  byte_last=1 exactly when byte_idx = NBYTES-1, or on the checksum byte when the macro is defined.
//  Simultaneous events:
//    - Block accept and last-byte transfer on one edge: both take effect; accepted block order is preserved.
//    - block_valid with holding full: overflow=1 the next cycle; stored data unchanged.
//  busy=0 only in IDLE with holding empty.
// CONFIGURATION
//  TDMRC_TX_CSUM_EN defined:
//    - After byte NBYTES-1 is transferred, state CSUM emits one extra byte = XOR of all NBYTES bytes.
//    - byte_last moves to that byte. The last-byte transfer rules apply to the CSUM transfer.
//    - The checksum accumulates as bytes load or transfer; it is zeroed on block load.
//  TDMRC_TX_CSUM_EN undefined:
//    - Exactly NBYTES bytes per block; no CSUM state; no accumulator logic.
// TESTING
//  T1 reset:
//    - rst 2 cycles -> all outputs 0 during rst.
//    - block_ready=1 and busy=0 the first cycle after.
//  T2 single block:
//    - block_in=40'h46494D4A44 pulse, byte_ready=1 -> byte_out 46,49,4D,4A,44 on 5 consecutive cycles.
//    - byte_last only on 44. byte_valid rises 1 cycle after accept and falls after 44.
//  T3 backpressure:
//    - byte_ready low 3 cycles while 49 is presented -> 49 held stable.
//    - No byte lost or duplicated; order unchanged.
//  T4 back-to-back:
//    - Block A 40'h0102030405, then block B 40'h0A0B0C0D0E 1 cycle later.
//    - Expect 10 bytes on 10 consecutive cycles (01..05, 0A..0E); byte_last on 05 and 0E.
//  T5 overflow:
//    - Three blocks on consecutive cycles with byte_ready=0 -> third dropped.
//    - overflow pulses once; after byte_ready=1 only the first two blocks appear.
//  T6 (TDMRC_TX_CSUM_EN) checksum:
//    - 40'h46494D4A44 -> 6 bytes 46,49,4D,4A,44,4C; byte_last on 4C.
//    - Reset during byte 2 -> byte_valid=0 next cycle; next block starts at byte 0.

Source files
------------

// File: rtl/tdmrc_byte_tx.sv
// tdmrc_byte_tx: serialises a flat NBYTES-byte block into a byte stream on a
// valid/ready interface, most significant byte first. A shift stage feeds the
// output while a holding stage buffers the next block, so consecutive blocks
// stream without a bubble.
// Optional build macro TDMRC_TX_CSUM_EN appends an XOR checksum byte per block.
module tdmrc_byte_tx #(
  parameter int NBYTES = 5,
  parameter int WIDTH  = 8
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NBYTES*WIDTH-1:0]   block_in,
  input  logic                      block_valid,
  output logic                      block_ready,
  output logic [WIDTH-1:0]          byte_out,
  output logic                      byte_valid,
  input  logic                      byte_ready,
  output logic                      byte_last,
  output logic                      busy,
  output logic                      overflow
);

  localparam int BW   = NBYTES * WIDTH;
  localparam int IDXW = $clog2(NBYTES + 1);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

`ifdef TDMRC_TX_CSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, CSUM = 2'd2} state_t;
`else
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;
`endif

  state_t              state_q, state_n;
  logic [BW-1:0]       shift_q, shift_n;
  logic [BW-1:0]       hold_q, hold_n;
  logic                hold_full_q, hold_full_n;
  logic [IDXW-1:0]     idx_q, idx_n;
  logic [WIDTH-1:0]    byte_out_q, byte_out_n;
  logic                byte_valid_q, byte_valid_n;
  logic                byte_last_q, byte_last_n;
  logic                overflow_q, overflow_n;
  logic                xfer, end_xfer, accept;
`ifdef TDMRC_TX_CSUM_EN
  logic [WIDTH-1:0]    csum_q, csum_n;
`endif

  // Byte k of a block sits at the top of the block for k=0 (MSB first).
  function automatic logic [WIDTH-1:0] sel_byte(input logic [BW-1:0] blk,
                                                input logic [IDXW-1:0] idx);
    logic [WIDTH-1:0] sel;
    sel = '0;
    for (int k = 0; k < NBYTES; k++) begin
      if (idx == IDXW'(k)) sel = blk[BW-1-WIDTH*k -: WIDTH];
    end
    return sel;
  endfunction

  assign block_ready = !hold_full_q && !rst;
  assign byte_out    = byte_out_q;
  assign byte_valid  = byte_valid_q;
  assign byte_last   = byte_last_q;
  assign overflow    = overflow_q;
  assign busy        = (state_q != IDLE) || hold_full_q;

  assign xfer   = byte_valid_q && byte_ready;
  assign accept = block_valid && block_ready;
`ifdef TDMRC_TX_CSUM_EN
  assign end_xfer = xfer && (state_q == CSUM);
`else
  assign end_xfer = xfer && (idx_q == LAST_IDX);
`endif

  // Next-state logic: stage movement, byte index and registered output values.
  always_comb begin
    state_n     = state_q;
    shift_n     = shift_q;
    hold_n      = hold_q;
    hold_full_n = hold_full_q;
    idx_n       = idx_q;
`ifdef TDMRC_TX_CSUM_EN
    csum_n      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (accept) begin
          shift_n = block_in;
          idx_n   = '0;
          state_n = SEND;
`ifdef TDMRC_TX_CSUM_EN
          csum_n  = '0;
`endif
        end
      end
      default: begin
        if (end_xfer) begin
          // Final byte leaves this edge: refill from holding first to keep order.
          if (hold_full_q) begin
            shift_n     = hold_q;
            hold_full_n = 1'b0;
            idx_n       = '0;
            state_n     = SEND;
`ifdef TDMRC_TX_CSUM_EN
            csum_n      = '0;
`endif
          end else if (accept) begin
            shift_n = block_in;
            idx_n   = '0;
            state_n = SEND;
`ifdef TDMRC_TX_CSUM_EN
            csum_n  = '0;
`endif
          end else begin
            idx_n   = '0;
            state_n = IDLE;
          end
        end else begin
          if (xfer) begin
`ifdef TDMRC_TX_CSUM_EN
            csum_n = csum_q ^ byte_out_q;
            if (idx_q == LAST_IDX) begin
              state_n = CSUM;
              idx_n   = IDXW'(NBYTES);
            end else begin
              idx_n = idx_q + IDXW'(1);
            end
`else
            idx_n = idx_q + IDXW'(1);
`endif
          end
          if (accept) begin
            hold_n      = block_in;
            hold_full_n = 1'b1;
          end
        end
      end
    endcase

    byte_valid_n = (state_n != IDLE);
    overflow_n   = block_valid && !block_ready;
`ifdef TDMRC_TX_CSUM_EN
    byte_out_n  = (state_n == CSUM) ? csum_n :
                  (state_n == SEND) ? sel_byte(shift_n, idx_n) : '0;
    byte_last_n = (state_n == CSUM);
`else
    byte_out_n  = (state_n == SEND) ? sel_byte(shift_n, idx_n) : '0;
    byte_last_n = (state_n == SEND) && (idx_n == LAST_IDX);
`endif
  end

  // State and output registers; reset clears both stages and all outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      shift_q      <= '0;
      hold_q       <= '0;
      hold_full_q  <= 1'b0;
      idx_q        <= '0;
      byte_out_q   <= '0;
      byte_valid_q <= 1'b0;
      byte_last_q  <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef TDMRC_TX_CSUM_EN
      csum_q       <= '0;
`endif
    end else begin
      state_q      <= state_n;
      shift_q      <= shift_n;
      hold_q       <= hold_n;
      hold_full_q  <= hold_full_n;
      idx_q        <= idx_n;
      byte_out_q   <= byte_out_n;
      byte_valid_q <= byte_valid_n;
      byte_last_q  <= byte_last_n;
      overflow_q   <= overflow_n;
`ifdef TDMRC_TX_CSUM_EN
      csum_q       <= csum_n;
`endif
    end
  end

endmodule

// File: tb/tb_tdmrc_byte_tx.sv
// Directed bench for tdmrc_byte_tx (NBYTES=5). Inputs change and outputs are
// sampled on the falling clock edge.
module tb_tdmrc_byte_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [39:0] block_in;
  logic        block_valid;
  logic        block_ready;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready;
  logic        byte_last;
  logic        busy;
  logic        overflow;

  int n_vec = 0;
  int n_err = 0;

  // Expected stream entries: {last, byte}
  logic [8:0] exp_q[$];

`ifdef TDMRC_TX_CSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif

  always #5 clk = ~clk;

  tdmrc_byte_tx #(.NBYTES(5), .WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .block_in   (block_in),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .byte_last  (byte_last),
    .busy       (busy),
    .overflow   (overflow)
  );

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(negedge clk);
  endtask

  task automatic push_block(input logic [39:0] blk);
    logic [7:0] b;
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < 5; k++) begin
      b = blk[39-8*k -: 8];
      x = x ^ b;
      exp_q.push_back({(k == 4) && !CS, b});
    end
    if (CS) exp_q.push_back({1'b1, x});
  endtask

  task automatic chk_entry(input string tag, input int i);
    logic [8:0] e;
    e = exp_q[i];
    chk({tag, "_valid"}, 40'(byte_valid), 40'(1'b1));
    chk({tag, "_byte"},  40'(byte_out),   40'(e[7:0]));
    chk({tag, "_last"},  40'(byte_last),  40'(e[8]));
  endtask

  initial begin
    rst = 1'b1; block_in = '0; block_valid = 1'b0; byte_ready = 1'b0;

    // T1 reset
    repeat (2) begin
      step;
      chk("rst_byte_out",    40'(byte_out),    40'h0);
      chk("rst_byte_valid",  40'(byte_valid),  40'h0);
      chk("rst_byte_last",   40'(byte_last),   40'h0);
      chk("rst_busy",        40'(busy),        40'h0);
      chk("rst_overflow",    40'(overflow),    40'h0);
      chk("rst_block_ready", 40'(block_ready), 40'h0);
    end
    rst = 1'b0;
    step;
    chk("post_rst_ready", 40'(block_ready), 40'h1);
    chk("post_rst_busy",  40'(busy),        40'h0);
    chk("post_rst_valid", 40'(byte_valid),  40'h0);

    // T2 single block
    exp_q.delete();
    push_block(40'h46494D4A44);
    block_in = 40'h46494D4A44; block_valid = 1'b1; byte_ready = 1'b1;
    step;
    block_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_entry("t2", i);
      step;
    end
    chk("t2_valid_fall", 40'(byte_valid), 40'h0);
    chk("t2_busy_end",   40'(busy),       40'h0);

`ifdef TDMRC_TX_CSUM_EN
    // T6 checksum byte value, hand computed
    chk("t6_csum_byte", 40'(exp_q[5][7:0]), 40'h4C);
`endif

    // T3 backpressure while byte 1 (49) is presented
    exp_q.delete();
    push_block(40'h46494D4A44);
    block_in = 40'h46494D4A44; block_valid = 1'b1;
    step;
    block_valid = 1'b0;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_entry("t3", i);
      if (i == 1) begin
        byte_ready = 1'b0;
        repeat (3) begin
          step;
          chk("t3_hold_byte",  40'(byte_out),   40'h49);
          chk("t3_hold_valid", 40'(byte_valid), 40'h1);
          chk("t3_hold_last",  40'(byte_last),  40'h0);
        end
        byte_ready = 1'b1;
      end
      step;
    end
    chk("t3_valid_fall", 40'(byte_valid), 40'h0);

    // T4 back-to-back blocks, second offered one cycle after the first
    exp_q.delete();
    push_block(40'h0102030405);
    push_block(40'h0A0B0C0D0E);
    block_in = 40'h0102030405; block_valid = 1'b1;
    step;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_entry("t4", i);
      if (i == 0) begin
        block_in = 40'h0A0B0C0D0E; block_valid = 1'b1;
      end else begin
        block_valid = 1'b0;
      end
      step;
    end
    chk("t4_valid_fall", 40'(byte_valid), 40'h0);
    chk("t4_busy_end",   40'(busy),       40'h0);

    // T5 overflow: three blocks while the sink stalls
    exp_q.delete();
    push_block(40'h1112131415);
    push_block(40'h2122232425);
    byte_ready = 1'b0;
    block_in = 40'h1112131415; block_valid = 1'b1;
    step;
    chk("t5_ovf_a", 40'(overflow), 40'h0);
    block_in = 40'h2122232425;
    step;
    chk("t5_ovf_b",   40'(overflow),    40'h0);
    chk("t5_ready_b", 40'(block_ready), 40'h0);
    block_in = 40'h3132333435;
    step;
    block_valid = 1'b0;
    chk("t5_ovf_pulse", 40'(overflow), 40'h1);
    step;
    chk("t5_ovf_clear", 40'(overflow), 40'h0);
    chk("t5_busy",      40'(busy),     40'h1);
    byte_ready = 1'b1;
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_entry("t5", i);
      step;
    end
    chk("t5_valid_fall", 40'(byte_valid),  40'h0);
    chk("t5_ready_end",  40'(block_ready), 40'h1);

    // Mid-stream reset while byte 2 is presented
    block_in = 40'h46494D4A44; block_valid = 1'b1;
    step;
    block_valid = 1'b0;
    chk("mr_b0", 40'(byte_out), 40'h46);
    step;
    chk("mr_b1", 40'(byte_out), 40'h49);
    step;
    chk("mr_b2", 40'(byte_out), 40'h4D);
    rst = 1'b1;
    step;
    chk("mr_valid", 40'(byte_valid), 40'h0);
    chk("mr_busy",  40'(busy),       40'h0);
    chk("mr_byte",  40'(byte_out),   40'h0);
    rst = 1'b0;
    exp_q.delete();
    push_block(40'h5566778899);
    block_in = 40'h5566778899; block_valid = 1'b1;
    step;
    block_valid = 1'b0;
    chk("mr_first", 40'(byte_out), 40'h55);
    for (int i = 0; i < exp_q.size(); i++) begin
      chk_entry("mr", i);
      step;
    end
    chk("mr_valid_fall", 40'(byte_valid), 40'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
